// File: rtl/capi_get_align_arb.sv
// Packet-level round-robin arbiter sharing one get-data aligner between `ways` requesters.
// Admitted packet owners are queued in order so the aligner output can be steered back to them.
module capi_get_align_arb #(
  parameter int ways       = 4,
  parameter int rc_width   = 1,
  parameter int fifo_depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ways-1:0]          i_v,
  output logic [ways-1:0]          i_r,
  input  logic [ways*130-1:0]      i_d,
  input  logic [ways*4-1:0]        i_s,
  input  logic [ways*4-1:0]        i_c,
  input  logic [ways-1:0]          i_e,
  input  logic [ways*rc_width-1:0] i_rc,
  output logic                     a_v,
  input  logic                     a_r,
  output logic [129:0]             a_d,
  output logic [3:0]               a_s,
  output logic [3:0]               a_c,
  output logic                     a_e,
  output logic [rc_width-1:0]      a_rc,
  input  logic                     a_o_v,
  output logic                     a_o_r,
  input  logic                     a_o_e,
  output logic [ways-1:0]          o_v,
  input  logic [ways-1:0]          o_r,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int IW = (ways > 1) ? $clog2(ways) : 1;
  localparam int FW = $clog2(fifo_depth);
  localparam int DW = 130;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [ways-1:0]   gnt;
  logic [IW-1:0]     gnt_id;
  logic [IW-1:0]     rr_ptr;
  logic [IW:0]       pick;
  logic              arb_hit;
  logic [IW-1:0]     arb_id;
  logic              grant;
  logic              a_end_xfer;
  logic              pop;

  logic [IW-1:0]     fifo_mem [fifo_depth];
  logic [FW-1:0]     wr_ptr;
  logic [FW-1:0]     rd_ptr;
  logic [FW:0]       cnt;
  logic              fifo_full;
  logic              fifo_nempty;
  logic [IW-1:0]     head_id;

  // First valid requester at or above ptr, wrapping; {hit, id}.
  function automatic logic [IW:0] rr_pick(input logic [ways-1:0] v, input logic [IW-1:0] ptr);
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int k = ways - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= ways) idx = idx - ways;
      if (v[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] id);
    return (id == IW'(ways - 1)) ? '0 : id + IW'(1);
  endfunction

  assign pick        = rr_pick(i_v, rr_ptr);
  assign arb_hit     = pick[IW];
  assign arb_id      = pick[IW-1:0];
  assign fifo_full   = (cnt == (FW+1)'(fifo_depth));
  assign fifo_nempty = (cnt != '0);
  assign head_id     = fifo_mem[rd_ptr];

  // Full check uses the pre-pop count, so a pop cycle never opens a slot early.
  assign grant      = (state == IDLE) && arb_hit && !fifo_full;
  assign a_end_xfer = a_v && a_r && a_e;
  assign pop        = a_o_v && a_o_r && a_o_e;

  // Input side: only the locked requester sees the aligner's ready.
  always_comb begin
    a_v  = (state == LOCK) && |(i_v & gnt);
    i_r  = (state == LOCK) ? (gnt & {ways{a_r}}) : '0;
    a_d  = i_d[int'(gnt_id)*DW +: DW];
    a_s  = i_s[int'(gnt_id)*4 +: 4];
    a_c  = i_c[int'(gnt_id)*4 +: 4];
    a_e  = i_e[gnt_id];
    a_rc = i_rc[int'(gnt_id)*rc_width +: rc_width];
  end

  // Output side: the FIFO head owns the aligner output until its end beat.
  always_comb begin
    a_o_r = fifo_nempty && o_r[head_id];
    o_v   = '0;
    for (int k = 0; k < ways; k++) begin
      o_v[k] = a_o_v && fifo_nempty && (head_id == IW'(k));
    end
    o_busy = (state == LOCK) || fifo_nempty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      o_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            gnt    <= {{(ways-1){1'b0}}, 1'b1} << arb_id;
            gnt_id <= arb_id;
            state  <= LOCK;
          end
        end
        LOCK: begin
          if (a_end_xfer) begin
            gnt    <= '0;
            rr_ptr <= rr_next(gnt_id);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (grant) wr_ptr <= wr_ptr + FW'(1);
      if (pop)   rd_ptr <= rd_ptr + FW'(1);
      case ({grant, pop})
        2'b10:   cnt <= cnt + (FW+1)'(1);
        2'b01:   cnt <= cnt - (FW+1)'(1);
        default: cnt <= cnt;
      endcase

      if (a_o_v && !fifo_nempty) o_err <= 1'b1;
    end
  end

  // Owner storage holds data only; validity comes from the reset pointers.
  always_ff @(posedge clk) begin
    if (grant) fifo_mem[wr_ptr] <= arb_id;
  end

endmodule

// File: tb/tb_capi_get_align_arb.sv
// Bench for capi_get_align_arb: per-cycle vector table with a data scoreboard,
// plus hand-written sequences for the sticky error and asynchronous reset in LOCK.
module tb_capi_get_align_arb;

  localparam int WAYS  = 4;
  localparam int RCW   = 1;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [WAYS-1:0]     i_v = '0;
  logic [WAYS-1:0]     i_r;
  logic [WAYS*130-1:0] i_d = '0;
  logic [WAYS*4-1:0]   i_s = '0;
  logic [WAYS*4-1:0]   i_c = '0;
  logic [WAYS-1:0]     i_e = '0;
  logic [WAYS*RCW-1:0] i_rc = '0;
  logic                a_v;
  logic                a_r = 1'b1;
  logic [129:0]        a_d;
  logic [3:0]          a_s;
  logic [3:0]          a_c;
  logic                a_e;
  logic [RCW-1:0]      a_rc;
  logic                a_o_v = 1'b0;
  logic                a_o_r;
  logic                a_o_e = 1'b0;
  logic [WAYS-1:0]     o_v;
  logic [WAYS-1:0]     o_r = '0;
  logic                o_busy;
  logic                o_err;

  capi_get_align_arb #(.ways(WAYS), .rc_width(RCW), .fifo_depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_s(i_s), .i_c(i_c), .i_e(i_e), .i_rc(i_rc),
    .a_v(a_v), .a_r(a_r), .a_d(a_d), .a_s(a_s), .a_c(a_c), .a_e(a_e), .a_rc(a_rc),
    .a_o_v(a_o_v), .a_o_r(a_o_r), .a_o_e(a_o_e),
    .o_v(o_v), .o_r(o_r), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] iv;
    logic [3:0] ie;
    int         beat;
    bit         aov;
    bit         aoe;
    logic [3:0] orr;
    bit         ev;
    logic [3:0] eir;
    int         src;
    logic [3:0] eov;
    bit         eaor;
    bit         ebusy;
  } row_t;

  row_t         rows[$];
  logic [138:0] sb[$];
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic row_t R(input bit rst, input logic [3:0] iv, input logic [3:0] ie,
                             input int beat, input bit aov, input bit aoe, input logic [3:0] orr,
                             input bit ev, input logic [3:0] eir, input int src,
                             input logic [3:0] eov, input bit eaor, input bit ebusy);
    row_t r;
    r.rst = rst; r.iv = iv; r.ie = ie; r.beat = beat; r.aov = aov; r.aoe = aoe; r.orr = orr;
    r.ev = ev; r.eir = eir; r.src = src; r.eov = eov; r.eaor = eaor; r.ebusy = ebusy;
    return r;
  endfunction

  function automatic logic [129:0] mk_d(input int k, input int b);
    return {2'(k), 64'(k + 1), 64'(b + 16 * k)};
  endfunction

  function automatic logic [138:0] mk_e(input int k, input int b);
    return {1'(k & 1), 4'(k + 8), 4'(k), mk_d(k, b)};
  endfunction

  task automatic chk(input string nm, input logic [138:0] act, input logic [138:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  task automatic drv(input logic [3:0] iv, input logic [3:0] ie, input int beat);
    i_v = iv;
    i_e = ie;
    for (int k = 0; k < WAYS; k++) begin
      i_d[130*k +: 130] = mk_d(k, beat);
      i_s[4*k +: 4]     = 4'(k);
      i_c[4*k +: 4]     = 4'(k + 8);
      i_rc[k]           = 1'(k & 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_v = '1; i_e = '1; a_r = 1'b1; a_o_v = 1'b1; a_o_e = 1'b1; o_r = '1;
    @(posedge clk); #1;
    chk("rst a_v",    139'(a_v),    139'(0));
    chk("rst i_r",    139'(i_r),    139'(0));
    chk("rst a_o_r",  139'(a_o_r),  139'(0));
    chk("rst o_v",    139'(o_v),    139'(0));
    chk("rst o_busy", 139'(o_busy), 139'(0));
    chk("rst o_err",  139'(o_err),  139'(0));
    @(posedge clk); #1;
    i_v = '0; i_e = '0; a_o_v = 1'b0; a_o_e = 1'b0; o_r = '0;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t r;

    // Round robin: requesters 0 and 2, 3-beat packets; then drain FIFO {0,2}.
    rows.push_back(R(1, 4'b0101, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    rows.push_back(R(0, 4'b0101, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0101, 4'b0000, 1, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0101, 4'b0001, 2, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0100, 2, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 1, 4'b0100, 2, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0100, 4'b0100, 2, 0, 0, 4'b0000, 1, 4'b0100, 2, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 1, 1, 4'b1111, 0, 4'b0000, 0, 4'b0001, 1, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 1, 1, 4'b1111, 0, 4'b0000, 0, 4'b0100, 1, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    // Fairness: all valid, 1-beat packets; one pop lets the fifth grant (0) through.
    rows.push_back(R(1, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 1, 4'b0010, 1, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 1, 4'b0100, 2, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 1, 1, 4'b1111, 1, 4'b1000, 3, 4'b0001, 1, 1));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    // Lock hold: requester 1 bubbles 3 cycles while requester 3 waits.
    rows.push_back(R(1, 4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    rows.push_back(R(0, 4'b1010, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0010, 1, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0010, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0010, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0010, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1010, 4'b0010, 1, 0, 0, 4'b0000, 1, 4'b0010, 1, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b1000, 4'b1000, 0, 0, 0, 4'b0000, 1, 4'b1000, 3, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    // FIFO full: four grants, blocked in the pop cycle, fifth grant after it.
    rows.push_back(R(1, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 1, 1, 4'b1111, 0, 4'b0000, 0, 4'b0001, 1, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0, 1));
    // Output steer: FIFO {2,1}, head 2 stalled by o_r until o_r[2] rises.
    rows.push_back(R(1, 4'b0100, 4'b0100, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    rows.push_back(R(0, 4'b0100, 4'b0100, 0, 0, 0, 4'b0000, 1, 4'b0100, 2, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 1, 4'b0010, 1, 4'b0000, 0, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0010, 0, 4'b0000, 0, 4'b0100, 0, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0110, 0, 4'b0000, 0, 4'b0100, 1, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 1, 1, 4'b0110, 0, 4'b0000, 0, 4'b0100, 1, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 1, 1, 4'b0110, 0, 4'b0000, 0, 4'b0010, 1, 1));
    rows.push_back(R(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));

    for (int i = 0; i < rows.size(); i++) begin
      r = rows[i];
      if (r.rst) do_reset();
      drv(r.iv, r.ie, r.beat);
      a_r = 1'b1; a_o_v = r.aov; a_o_e = r.aoe; o_r = r.orr;
      if (r.ev) sb.push_back(mk_e(r.src, r.beat));
      @(negedge clk);
      chk($sformatf("r%0d a_v", i),    139'(a_v),    139'(r.ev));
      chk($sformatf("r%0d i_r", i),    139'(i_r),    139'(r.eir));
      chk($sformatf("r%0d o_v", i),    139'(o_v),    139'(r.eov));
      chk($sformatf("r%0d a_o_r", i),  139'(a_o_r),  139'(r.eaor));
      chk($sformatf("r%0d o_busy", i), 139'(o_busy), 139'(r.ebusy));
      if (a_v && a_r) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL r%0d beat: got unexpected transfer want none", i);
        end else begin
          chk($sformatf("r%0d beat", i), {a_rc, a_c, a_s, a_d}, sb.pop_front());
          chk($sformatf("r%0d a_e", i), 139'(a_e), 139'(r.ie[r.src]));
        end
      end
      @(posedge clk); #1;
    end
    chk("sb drained", 139'(sb.size()), 139'(0));

    // Sticky protocol error.
    do_reset();
    a_o_v = 1'b1; a_o_e = 1'b0; o_r = 4'b1111;
    @(negedge clk);
    chk("err a_o_r", 139'(a_o_r), 139'(0));
    chk("err o_v",   139'(o_v),   139'(0));
    chk("err pre",   139'(o_err), 139'(0));
    @(posedge clk); #1;
    a_o_v = 1'b0; o_r = '0;
    @(negedge clk);
    chk("err set", 139'(o_err), 139'(1));
    drv(4'b0001, 4'b0001, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("err sticky", 139'(o_err), 139'(1));
    do_reset();

    // Asynchronous reset while locked on requester 1, with owner 0 at the FIFO head.
    drv(4'b0001, 4'b0001, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drv(4'b0011, 4'b0000, 0);
    @(posedge clk); #1;
    a_o_v = 1'b1; a_o_e = 1'b0; o_r = 4'b1111;
    #1;
    chk("lock a_v",    139'(a_v),    139'(1));
    chk("lock i_r",    139'(i_r),    139'(4'b0010));
    chk("lock o_v",    139'(o_v),    139'(4'b0001));
    chk("lock o_busy", 139'(o_busy), 139'(1));
    #1 reset = 1'b1;
    #1;
    chk("arst a_v",    139'(a_v),    139'(0));
    chk("arst i_r",    139'(i_r),    139'(0));
    chk("arst o_v",    139'(o_v),    139'(0));
    chk("arst o_busy", 139'(o_busy), 139'(0));
    a_o_v = 1'b0; o_r = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("arst idle a_v", 139'(a_v), 139'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst prio a_v",  139'(a_v), 139'(1));
    chk("arst prio i_r",  139'(i_r), 139'(4'b0001));
    chk("arst prio beat", {a_rc, a_c, a_s, a_d}, mk_e(0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
